smbm_cmd_issue: RTL and testbench

Command front end for the sorted multi-metric buffer manager (`smbm`). Accepts ADD/DELETE/READ requests over a valid/ready interface and buffers them in a small FIFO. Issues one command at a time to `smbm` using its single-cycle opcode protocol, holds the operands stable until `smbm` asserts `done`, then reports completion. Tracks list occupancy so that ADD on a full list and DELETE on an empty list are rejected before they reach `smbm`.

---
 rtl/smbm_cmd_issue.sv | 237 +++++++++++++++++++++++
 tb/tb_smbm_cmd_issue.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smbm_cmd_issue.sv
// smbm_cmd_issue
//   Command front end for the sorted multi-metric buffer manager (smbm).
//   Requests (ADD / DELETE / READ_FILTERED / READ_ALL) are accepted over a
//   valid/ready handshake into a small circular FIFO. The head is issued to
//   smbm as a single-cycle opcode pulse, operands are held until smbm
//   reports done, and a one-cycle completion pulse is produced. List
//   occupancy is tracked locally so ADD-on-full and DELETE-on-empty are
//   rejected without ever reaching smbm.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_valid/ready   request handshake; ready == FIFO not full
//   req_op            0=ADD 1=DELETE 2=READ_FILTERED 3=READ_ALL
//   req_id            id for ADD/DELETE
//   req_metric        NUM_OF_METRICS x 8-bit metric values for ADD
//   req_mask          filter bit vector for READ_FILTERED
//   req_metricx       metric list selector for READs
//   smbm_opcode       opcode pulse to smbm, 3'b111 when not issuing
//   smbm_opcode_in    read sub-mode to smbm
//   smbm_id/metric_val/in/metricx  operand registers to smbm
//   smbm_done         command-complete strobe from smbm
//   cmpl_valid        one-cycle completion pulse
//   cmpl_op, cmpl_err op of completed request; err=1 means rejected
//   occupancy         number of ids currently held in smbm
//   busy              FSM not idle or FIFO non-empty
module smbm_cmd_issue #(
  parameter int BIT_VEC_SIZE       = 256,
  parameter int BIT_VEC_SIZE_LOG   = 8,
  parameter int NUM_OF_METRICS     = 8,
  parameter int NUM_OF_METRICS_LOG = 3,
  parameter int FIFO_DEPTH         = 4,
  parameter int FIFO_DEPTH_LOG     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [BIT_VEC_SIZE_LOG-1:0]   req_id,
  input  logic [NUM_OF_METRICS*8-1:0]   req_metric,
  input  logic [BIT_VEC_SIZE-1:0]       req_mask,
  input  logic [NUM_OF_METRICS_LOG-1:0] req_metricx,
  output logic [2:0]                    smbm_opcode,
  output logic [2:0]                    smbm_opcode_in,
  output logic [BIT_VEC_SIZE_LOG-1:0]   smbm_id,
  output logic [NUM_OF_METRICS*8-1:0]   smbm_metric_val,
  output logic [BIT_VEC_SIZE-1:0]       smbm_in,
  output logic [NUM_OF_METRICS_LOG-1:0] smbm_metricx,
  input  logic                          smbm_done,
  output logic                          cmpl_valid,
  output logic [1:0]                    cmpl_op,
  output logic                          cmpl_err,
  output logic [BIT_VEC_SIZE_LOG:0]     occupancy,
  output logic                          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_DEL = 2'd1;
  localparam logic [1:0] OP_RDF = 2'd2;
  localparam logic [1:0] OP_RDA = 2'd3;

  localparam int MW = NUM_OF_METRICS * 8;
  localparam logic [BIT_VEC_SIZE_LOG:0] OCC_FULL = (BIT_VEC_SIZE_LOG+1)'(BIT_VEC_SIZE);
  localparam logic [BIT_VEC_SIZE_LOG:0] OCC_ONE  = (BIT_VEC_SIZE_LOG+1)'(1);
  localparam logic [FIFO_DEPTH_LOG:0]   CNT_FULL = (FIFO_DEPTH_LOG+1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_LOG:0]   CNT_ONE  = (FIFO_DEPTH_LOG+1)'(1);

  // ---------------------------------------------------------------- FIFO
  logic [1:0]                    fop_q  [FIFO_DEPTH];
  logic [BIT_VEC_SIZE_LOG-1:0]   fid_q  [FIFO_DEPTH];
  logic [MW-1:0]                 fmet_q [FIFO_DEPTH];
  logic [BIT_VEC_SIZE-1:0]       fmask_q[FIFO_DEPTH];
  logic [NUM_OF_METRICS_LOG-1:0] fmx_q  [FIFO_DEPTH];

  logic [FIFO_DEPTH_LOG-1:0] wr_q, rd_q;
  logic [FIFO_DEPTH_LOG:0]   cnt_q;
  logic                      push, pop, full;

  assign full      = (cnt_q == CNT_FULL);
  assign req_ready = !full;
  // No bypass: a full FIFO refuses a push even when the head pops this cycle.
  assign push      = req_valid && !full;

  always_ff @(posedge clk) begin
    if (push) begin
      fop_q[wr_q]   <= req_op;
      fid_q[wr_q]   <= req_id;
      fmet_q[wr_q]  <= req_metric;
      fmask_q[wr_q] <= req_mask;
      fmx_q[wr_q]   <= req_metricx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  logic [1:0] head_op;
  assign head_op = fop_q[rd_q];

  // ---------------------------------------------------------------- FSM
  state_t                        state_q, state_d;
  logic [1:0]                    op_q;
  logic [2:0]                    opc_in_q, opc_in_d;
  logic [BIT_VEC_SIZE_LOG-1:0]   id_q;
  logic [MW-1:0]                 met_q;
  logic [BIT_VEC_SIZE-1:0]       mask_q;
  logic [NUM_OF_METRICS_LOG-1:0] mx_q;
  logic                          load;
  logic                          cmpl_valid_q, cmpl_valid_d;
  logic                          cmpl_err_q, cmpl_err_d;
  logic [1:0]                    cmpl_op_q, cmpl_op_d;
  logic [BIT_VEC_SIZE_LOG:0]     occ_q, occ_d;
  logic                          reject;

  assign reject = ((head_op == OP_ADD) && (occ_q == OCC_FULL)) ||
                  ((head_op == OP_DEL) && (occ_q == '0));

  always_comb begin
    case (head_op)
      OP_RDF:  opc_in_d = 3'b010;
      OP_RDA:  opc_in_d = 3'b101;
      default: opc_in_d = 3'b000;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    load         = 1'b0;
    cmpl_valid_d = 1'b0;
    cmpl_err_d   = cmpl_err_q;
    cmpl_op_d    = cmpl_op_q;
    occ_d        = occ_q;
    smbm_opcode  = 3'b111;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          if (reject) begin
            pop          = 1'b1;
            cmpl_valid_d = 1'b1;
            cmpl_err_d   = 1'b1;
            cmpl_op_d    = head_op;
          end else begin
            load    = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        case (op_q)
          OP_ADD:  smbm_opcode = 3'b000;
          OP_DEL:  smbm_opcode = 3'b001;
          default: smbm_opcode = 3'b010;
        endcase
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The head stays in the FIFO until smbm finishes, so it is popped here.
        if (smbm_done) begin
          pop          = 1'b1;
          cmpl_valid_d = 1'b1;
          cmpl_err_d   = 1'b0;
          cmpl_op_d    = op_q;
          if (op_q == OP_ADD)      occ_d = occ_q + OCC_ONE;
          else if (op_q == OP_DEL) occ_d = occ_q - OCC_ONE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmpl_valid_q <= 1'b0;
      cmpl_err_q   <= 1'b0;
      cmpl_op_q    <= '0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_err_q   <= cmpl_err_d;
      cmpl_op_q    <= cmpl_op_d;
      occ_q        <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      opc_in_q <= '0;
      id_q     <= '0;
      met_q    <= '0;
      mask_q   <= '0;
      mx_q     <= '0;
    end else if (load) begin
      op_q     <= head_op;
      opc_in_q <= opc_in_d;
      id_q     <= fid_q[rd_q];
      met_q    <= fmet_q[rd_q];
      mask_q   <= fmask_q[rd_q];
      mx_q     <= fmx_q[rd_q];
    end
  end

  assign smbm_opcode_in  = opc_in_q;
  assign smbm_id         = id_q;
  assign smbm_metric_val = met_q;
  assign smbm_in         = mask_q;
  assign smbm_metricx    = mx_q;
  assign cmpl_valid      = cmpl_valid_q;
  assign cmpl_err        = cmpl_err_q;
  assign cmpl_op         = cmpl_op_q;
  assign occupancy       = occ_q;
  assign busy            = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_smbm_cmd_issue.sv
// Testbench for smbm_cmd_issue: random and directed requests, a behavioural
// smbm responder, and a scoreboard of expected issues and completions.
module tb_smbm_cmd_issue;

  localparam int BVS = 256;
  localparam int BVL = 8;
  localparam int NM  = 8;
  localparam int NML = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_op;
  logic [BVL-1:0] req_id;
  logic [NM*8-1:0] req_metric;
  logic [BVS-1:0] req_mask;
  logic [NML-1:0] req_metricx;
  logic [2:0]     smbm_opcode, smbm_opcode_in;
  logic [BVL-1:0] smbm_id;
  logic [NM*8-1:0] smbm_metric_val;
  logic [BVS-1:0] smbm_in;
  logic [NML-1:0] smbm_metricx;
  logic           smbm_done;
  logic           cmpl_valid;
  logic [1:0]     cmpl_op;
  logic           cmpl_err;
  logic [BVL:0]   occupancy;
  logic           busy;

  smbm_cmd_issue #(
    .BIT_VEC_SIZE(BVS), .BIT_VEC_SIZE_LOG(BVL),
    .NUM_OF_METRICS(NM), .NUM_OF_METRICS_LOG(NML),
    .FIFO_DEPTH(4), .FIFO_DEPTH_LOG(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_id(req_id), .req_metric(req_metric), .req_mask(req_mask),
    .req_metricx(req_metricx),
    .smbm_opcode(smbm_opcode), .smbm_opcode_in(smbm_opcode_in),
    .smbm_id(smbm_id), .smbm_metric_val(smbm_metric_val),
    .smbm_in(smbm_in), .smbm_metricx(smbm_metricx),
    .smbm_done(smbm_done),
    .cmpl_valid(cmpl_valid), .cmpl_op(cmpl_op), .cmpl_err(cmpl_err),
    .occupancy(occupancy), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] op;
    logic       err;
    int         occ;
    int         acc;
    int         lat;
    bit         chk;
  } sb_t;

  typedef struct {
    logic [2:0]      opc;
    logic [2:0]      opc_in;
    logic [BVL-1:0]  id;
    logic [NM*8-1:0] met;
    logic [BVS-1:0]  mask;
    logic [NML-1:0]  mx;
  } is_t;

  sb_t sb_q[$];
  is_t is_q[$];
  int  m_occ = 0;
  int  extra_dly = 0;
  bit  noise = 1'b0;
  int  issues_seen = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: list occupancy evolves in acceptance order, because
  // commands are processed strictly in order.
  task automatic model_accept(input logic [1:0] op, input logic [BVL-1:0] id,
                              input logic [NM*8-1:0] met, input logic [BVS-1:0] mask,
                              input logic [NML-1:0] mx, input bit chk_lat, input int acc);
    sb_t s;
    is_t e;
    s.op  = op;
    s.err = (op == 2'd0 && m_occ == BVS) || (op == 2'd1 && m_occ == 0);
    if (!s.err) begin
      if (op == 2'd0) m_occ = m_occ + 1;
      if (op == 2'd1) m_occ = m_occ - 1;
      e.opc    = (op == 2'd0) ? 3'b000 : (op == 2'd1) ? 3'b001 : 3'b010;
      e.opc_in = (op == 2'd2) ? 3'b010 : (op == 2'd3) ? 3'b101 : 3'b000;
      e.id = id; e.met = met; e.mask = mask; e.mx = mx;
      is_q.push_back(e);
    end
    s.occ = m_occ;
    s.acc = acc;
    s.lat = s.err ? 1 : (op >= 2'd2 ? 3 : 4);
    s.chk = chk_lat;
    sb_q.push_back(s);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [1:0] op, input logic [BVL-1:0] id,
                      input logic [NM*8-1:0] met, input logic [BVS-1:0] mask,
                      input logic [NML-1:0] mx, input bit chk_lat);
    int n;
    int acc;
    n = 0;
    req_valid = 1'b1;
    req_op = op; req_id = id; req_metric = met; req_mask = mask; req_metricx = mx;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: ready stayed %0b expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    @(posedge clk);
    model_accept(op, id, met, mask, mx, chk_lat, acc);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [1:0] op, input bit chk_lat);
    logic [BVS-1:0] m;
    for (int i = 0; i < BVS / 32; i++) m[i*32 +: 32] = $urandom;
    send(op, BVL'($urandom), {$urandom, $urandom}, m, NML'($urandom), chk_lat);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy || sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d expected 0/0", busy, sb_q.size());
    end
  endtask

  // Completion monitor.
  initial begin
    sb_t s;
    forever begin
      @(negedge clk);
      if (!rst && cmpl_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cmpl: cmpl_valid=1 op=%0d expected no completion", cmpl_op);
        end else begin
          s = sb_q.pop_front();
          chk("cmpl_op", 256'(cmpl_op), 256'(s.op));
          chk("cmpl_err", 256'(cmpl_err), 256'(s.err));
          chk("cmpl_occupancy", 256'(occupancy), 256'(s.occ));
          if (s.chk) chk("cmpl_latency", 256'(cyc - s.acc), 256'(s.lat));
        end
      end
    end
  end

  // Behavioural smbm: done one cycle after ISSUE for READ, two for ADD/DELETE
  // (plus optional extra delay); stray done pulses while idle when noise is on.
  initial begin
    is_t e;
    is_t cap;
    int  w;
    bit  aborted;
    smbm_done = 1'b0;
    forever begin
      @(negedge clk);
      smbm_done = 1'b0;
      if (rst) continue;
      if (smbm_opcode !== 3'b111) begin
        issues_seen++;
        if (is_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_issue: opcode=%0b expected 111", smbm_opcode);
          continue;
        end
        e = is_q.pop_front();
        chk("issue_opcode", 256'(smbm_opcode), 256'(e.opc));
        chk("issue_opcode_in", 256'(smbm_opcode_in), 256'(e.opc_in));
        chk("issue_id", 256'(smbm_id), 256'(e.id));
        chk("issue_metric", 256'(smbm_metric_val), 256'(e.met));
        chk("issue_mask", smbm_in, e.mask);
        chk("issue_metricx", 256'(smbm_metricx), 256'(e.mx));
        cap = e;
        w = ((e.opc == 3'b010) ? 1 : 2) + extra_dly;
        aborted = 1'b0;
        for (int i = 0; i < w; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          chk("wait_opcode_idle", 256'(smbm_opcode), 256'(3'b111));
        end
        if (!aborted) begin
          chk("held_id", 256'(smbm_id), 256'(cap.id));
          chk("held_mask", smbm_in, cap.mask);
          chk("held_metric", 256'(smbm_metric_val), 256'(cap.met));
          smbm_done = 1'b1;
        end
      end else if (noise && $urandom_range(0, 7) == 0) begin
        smbm_done = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BVS-1:0] ones;
    int base;
    int n;
    ones = '1;
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = '0; req_id = '0; req_metric = '0; req_mask = '0; req_metricx = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset values
    chk("rst_req_ready", 256'(req_ready), 256'(1'b1));
    chk("rst_opcode", 256'(smbm_opcode), 256'(3'b111));
    chk("rst_opcode_in", 256'(smbm_opcode_in), 256'(0));
    chk("rst_id", 256'(smbm_id), 256'(0));
    chk("rst_metric", 256'(smbm_metric_val), 256'(0));
    chk("rst_mask", smbm_in, 256'(0));
    chk("rst_metricx", 256'(smbm_metricx), 256'(0));
    chk("rst_cmpl_valid", 256'(cmpl_valid), 256'(0));
    chk("rst_cmpl_err", 256'(cmpl_err), 256'(0));
    chk("rst_cmpl_op", 256'(cmpl_op), 256'(0));
    chk("rst_occupancy", 256'(occupancy), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));

    // DELETE on empty list is rejected
    send(2'd1, 8'd3, '0, '0, '0, 1'b1);
    wait_idle();
    chk("del_empty_occ", 256'(occupancy), 256'(0));

    // ADD id=5, all metrics 8'h10
    send(2'd0, 8'd5, {NM{8'h10}}, '0, '0, 1'b1);
    wait_idle();
    chk("add_occ", 256'(occupancy), 256'(1));

    // READ_FILTERED, metricx=2, all-ones mask
    send(2'd2, '0, '0, ones, 3'd2, 1'b1);
    wait_idle();

    // READ_ALL
    send_rand(2'd3, 1'b1);
    wait_idle();

    // Back-to-back: FIFO fills after the 4th accept
    for (int k = 0; k < 4; k++) send_rand(2'd0, 1'b0);
    chk("ready_after_4", 256'(req_ready), 256'(0));
    send_rand(2'd0, 1'b0);
    wait_idle();

    // Random traffic with variable done delay and stray done pulses
    for (int k = 0; k < 150; k++) begin
      extra_dly = $urandom_range(0, 2);
      noise = 1'b1;
      send_rand(2'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    wait_idle();
    extra_dly = 0;
    noise = 1'b0;

    // Fill the list, then one ADD too many
    while (m_occ < BVS) send_rand(2'd0, 1'b0);
    wait_idle();
    chk("full_occ", 256'(occupancy), 256'(BVS));
    send_rand(2'd0, 1'b1);
    wait_idle();
    chk("full_reject_occ", 256'(occupancy), 256'(BVS));
    send_rand(2'd1, 1'b1);
    wait_idle();

    // Reset while WAITing on an ADD
    extra_dly = 4;
    base = issues_seen;
    send_rand(2'd0, 1'b0);
    n = 0;
    while (issues_seen == base && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_issued", 256'(issues_seen != base), 256'(1));
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    sb_q.delete();
    is_q.delete();
    m_occ = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_occ", 256'(occupancy), 256'(0));
    chk("midrst_opcode", 256'(smbm_opcode), 256'(3'b111));
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_ready", 256'(req_ready), 256'(1));
    chk("midrst_cmpl_valid", 256'(cmpl_valid), 256'(0));
    extra_dly = 0;
    repeat (10) @(negedge clk);

    // Recovery after reset
    send(2'd0, 8'd9, {NM{8'h22}}, '0, '0, 1'b1);
    wait_idle();
    chk("recover_occ", 256'(occupancy), 256'(1));
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
